// File: rtl/mem_array_reader.sv
// rtl/mem_array_reader.sv - in-order reader for the circular register array
// Overflow state, ovf flag and resync pulse are built only with MEM_READER_OVF_EN.
module mem_array_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level
`ifdef MEM_READER_OVF_EN
  ,
  output logic              ovf,
  input  logic              resync
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] OVF    = 2'd2;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_nxt;
  logic [ADDR_W:0]   count, count_nxt;
  logic              fetch, full, lapped, flush_out;

  assign full   = (count == FULL);
  assign fetch  = (state != OVF) && (count != '0) && (!out_valid || out_ready);
  assign lapped = wr_strobe && full && !fetch && (state != OVF);

  assign mem_addr = rd_ptr;
  assign level    = count;

`ifdef MEM_READER_OVF_EN
  logic [ADDR_W-1:0] wr_shadow;

  assign flush_out = lapped || (state == OVF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_shadow <= '0;
      ovf       <= 1'b0;
    end else begin
      if (wr_strobe)
        wr_shadow <= wr_shadow + ADDR_W'(1);
      if (lapped)
        ovf <= 1'b1;
      else if (state == OVF && resync)
        ovf <= 1'b0;
    end
  end
`else
  assign flush_out = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    rd_nxt    = rd_ptr;
    state_nxt = state;
    if (fetch && !wr_strobe)
      count_nxt = count - (ADDR_W+1)'(1);
    else if (wr_strobe && !fetch && !full)
      count_nxt = count + (ADDR_W+1)'(1);
    if (fetch)
      rd_nxt = rd_ptr + ADDR_W'(1);
    case (state)
      IDLE:    if (count_nxt != '0) state_nxt = STREAM;
      STREAM:  if (count == '0 && !out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef MEM_READER_OVF_EN
    if (lapped)
      state_nxt = OVF;
    if (state == OVF) begin
      state_nxt = OVF;
      if (resync) begin
        // Restart exactly where the writer will store its next word.
        rd_nxt    = wr_shadow + ADDR_W'(wr_strobe);
        count_nxt = '0;
        state_nxt = IDLE;
      end
    end
`else
    // The writer overwrote the oldest unread word, so skip past it.
    if (lapped)
      rd_nxt = rd_ptr + ADDR_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (fetch) begin
        out_data  <= mem_data;
        out_valid <= 1'b1;
      end else if (out_ready || flush_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_array_reader.sv
// tb/tb_mem_array_reader.sv - scoreboard bench for mem_array_reader
// Covers both builds; the overflow scenario follows MEM_READER_OVF_EN.
module tb_mem_array_reader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_strobe = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [ADDR_W:0]   level;
`ifdef MEM_READER_OVF_EN
  logic              ovf;
  logic              resync = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] first_word;
  int errors = 0;
  int checks = 0;
  int hs = 0;
  int base = 0;
  int wr_since_rst = 0;

  always #5 clk = ~clk;

  mem_array_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_strobe (wr_strobe),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
`ifdef MEM_READER_OVF_EN
    ,
    .ovf       (ovf),
    .resync    (resync)
`endif
  );

  // Writer side of the array: stores at its own wrapping pointer.
  assign mem_data = mem[mem_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) wp <= '0;
    else if (wr_strobe) begin
      mem[wp] <= wdata;
      wp <= wp + 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        check("stream_word", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_strobe = 1'b0;
    out_ready = 1'b0;
`ifdef MEM_READER_OVF_EN
    resync = 1'b0;
`endif
    exp_q.delete();
    wr_since_rst = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write(input logic [DATA_W-1:0] d);
    wr_strobe = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    wr_since_rst++;
    tick();
    wr_strobe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check("reset_valid", out_valid, 0);
    check("reset_level", level, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_data", out_data, 0);

    // Three words streamed straight through.
    out_ready = 1'b1;
    base = hs;
    write(8'h11); write(8'h22); write(8'h33);
    check("t1_valid_mid", out_valid, 1);
    check("t1_data_mid", out_data, 8'h22);
    tick(); tick();
    check("t1_count", hs - base, 3);
    check("t1_level", level, 0);
    check("t1_valid_end", out_valid, 0);

    // Back-pressure, then back-to-back drain.
    out_ready = 1'b0;
    first_word = 8'($urandom);
    write(first_word);
    for (int i = 0; i < 4; i++) write(8'($urandom));
    check("t2_level", level, 4);
    check("t2_valid", out_valid, 1);
    check("t2_held", out_data, first_word);
    base = hs;
    out_ready = 1'b1;
    repeat (5) tick();
    check("t2_count", hs - base, 5);
    check("t2_valid_end", out_valid, 0);

    // Twenty words across the pointer wrap.
    base = hs;
    for (int i = 0; i < 20; i++) write(8'($urandom));
    tick(); tick();
    check("t3_count", hs - base, 20);
    check("t3_level", level, 0);
    check("t3_addr", mem_addr, wr_since_rst % DEPTH);

    // Writer laps the reader.
    do_reset();
    first_word = 8'($urandom);
    write(first_word);
    for (int i = 1; i < 18; i++) write(8'($urandom));
`ifdef MEM_READER_OVF_EN
    check("t4_ovf_set", ovf, 1);
    check("t4_valid", out_valid, 0);
    exp_q.delete();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("t4_ovf_clr", ovf, 0);
    check("t4_level", level, 0);
    check("t4_addr", mem_addr, 2);
    out_ready = 1'b1;
    write(8'hAB);
    tick();
    check("t4_valid_new", out_valid, 1);
    check("t4_data_new", out_data, 8'hAB);
    tick();
    check("t4_drained", exp_q.size(), 0);
`else
    check("t4_level", level, 16);
    check("t4_valid", out_valid, 1);
    check("t4_held", out_data, first_word);
    exp_q.delete(1);
    base = hs;
    out_ready = 1'b1;
    repeat (17) tick();
    check("t4_count", hs - base, 17);
    check("t4_valid_end", out_valid, 0);
    check("t4_level_end", level, 0);
    check("t4_drained", exp_q.size(), 0);
`endif

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 7; i++) write(8'($urandom));
    check("t5_level_pre", level, 6);
    check("t5_valid_pre", out_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_level", level, 0);
    check("t5_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    wr_since_rst = 0;

    // Random traffic without lapping, including same-address fetch/write cycles.
    tick();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (exp_q.size() <= DEPTH && $urandom_range(0, 2) != 0) begin
        wr_strobe = 1'b1;
        wdata = 8'($urandom);
        exp_q.push_back(wdata);
        wr_since_rst++;
      end else begin
        wr_strobe = 1'b0;
      end
      tick();
    end
    wr_strobe = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_level", level, 0);
    check("rnd_valid", out_valid, 0);
    check("rnd_addr", mem_addr, wr_since_rst % DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_array_reader.md
# mem_array_reader

Read-side companion of the team's single-port circular register array. The writer stores one word per strobe at an address that auto-increments and wraps. This block tracks the writer's progress and fetches unread words in write order through the array's asynchronous read port. It presents them to a downstream consumer on a valid/ready stream and detects when the writer laps it.

## Interface
- `DATA_W`, 8: word width.
- `ADDR_W`, 4: array address width; `DEPTH` = 2**ADDR_W (16).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_strobe` in 1: writer stores one word at the next clock edge, at its own pointer.
- `mem_addr` out ADDR_W: read address to the array (equals `rd_ptr`).
- `mem_data` in DATA_W: combinational read data for `mem_addr`.
- `out_data` out DATA_W: registered output word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `level` out ADDR_W+1: unread words still in the array (0..DEPTH).
- `ovf` out 1: sticky overflow flag (present only with `MEM_READER_OVF_EN`).
- `resync` in 1: single-cycle pulse that clears overflow (present only with `MEM_READER_OVF_EN`).

## Operation
- Internal state:
  - `wr_shadow` (ADDR_W): copy of the writer pointer; increments on each `wr_strobe`.
  - `rd_ptr` (ADDR_W).
  - `count` (ADDR_W+1).
  - FSM: IDLE, STREAM, OVF.
- Reset values: `rd_ptr`=0, `wr_shadow`=0, `count`=0, `out_data`=0, `out_valid`=0, `ovf`=0, state IDLE. All outputs follow from these, so `mem_addr`=0 and `level`=0.
- Fetch condition: state is not OVF, `count`>0, and the output register is free (`!out_valid || out_ready`).
- On fetch: `out_data` <= `mem_data`, `out_valid` <= 1, `rd_ptr` increments (mod DEPTH), `count` decrements.
- `count` update: +1 on `wr_strobe`, -1 on fetch. Both in the same cycle leave it unchanged.
- Handshake: a word transfers when `out_valid && out_ready`. With nothing to fetch that cycle, `out_valid` drops to 0.
- FSM transitions:
  - IDLE -> STREAM when `count` becomes nonzero.
  - STREAM -> IDLE when `count`=0 and `out_valid`=0.
  - STREAM or IDLE -> OVF on overflow.
- Overflow: `wr_strobe` while `count`=DEPTH and no fetch in that cycle. The writer overwrites the oldest unread word.
- OVF state:
  - `out_valid` is forced to 0 on the next edge; the held word is discarded.
  - No fetches; `ovf`=1.
  - `wr_shadow` keeps tracking strobes.
- `resync` in OVF: `rd_ptr` <= `wr_shadow` (plus 1 if `wr_strobe` is high that cycle), `count` <= 0, `ovf` <= 0, state IDLE. `resync` has no effect outside OVF.
- Wrap-around: all pointers wrap from DEPTH-1 to 0; `count` never wraps.
- Same-address hazard: a fetch at `rd_ptr` in the same cycle the writer overwrites that location returns the old word. This is legal because the write lands at the edge.

## Timing
- Write-to-availability: a strobe in cycle t makes the word fetchable in cycle t+1; `out_valid` rises at the edge ending t+1.
- Throughput: one word per cycle while `count`>0 and `out_ready`=1.
- `mem_addr` is driven from a register; `out_data` and `out_valid` are registered. There is no combinational path from `out_ready` to any output.
- Reset asserted mid-stream clears everything immediately. Words held in the array are not recovered.

## Configuration
- `MEM_READER_OVF_EN` defined:
  - `ovf` and `resync` ports exist.
  - OVF state behaves as above.
- Undefined:
  - No OVF state and no `ovf`/`resync` ports.
  - An overflowing strobe drops the oldest word: `rd_ptr` increments and `count` stays at DEPTH.
  - Streaming continues uninterrupted.

## Test plan
- Reset, then 3 strobes with the writer storing 0x11, 0x22, 0x33, `out_ready`=1 -> `out_data` 0x11, 0x22, 0x33 on consecutive cycles, each with `out_valid`; then `level`=0 and IDLE.
- 5 strobes with `out_ready`=0 -> `level`=4 and `out_valid`=1 holding word 0. Then `out_ready`=1 -> remaining words delivered back-to-back in order.
- 20 strobes with continuous `out_ready`=1 -> all 20 words delivered in order; `rd_ptr` wraps 15->0 with no gap.
- `out_ready`=0 and 18 strobes, macro defined -> `ovf`=1 and `out_valid`=0 after the 18th strobe. `resync` -> `ovf`=0, `level`=0, `mem_addr`=2. A new strobe storing 0xAB -> `out_data`=0xAB.
- Same 18-strobe stimulus, macro undefined -> `level`=16 and no stall. Drained output starts with the word written by strobe 3 (strobe 1 is held in the output register, strobe 2 is dropped).
- Assert `rst` with `level`=6 and `out_valid`=1 -> same cycle `out_valid`=0, `level`=0, `mem_addr`=0.
